// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU memory responder.
// Command size encodings, block geometry, memory read latency and the FSM state set.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_8B      = 2'd0,
        SZ_32B     = 2'd1,
        SZ_4B      = 2'd2,
        SZ_32B_ALT = 2'd3
    } cmd_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int BEATS_PER_BLOCK = 4;
    localparam int READ_LATENCY    = 1;

    function automatic logic is_full_block(input cmd_size_e sz);
        return (sz == SZ_32B) || (sz == SZ_32B_ALT);
    endfunction

endpackage

// File: rtl/gpu_mem_responder_if.sv
// GPU command/response bus plus the 64-bit backing-memory port of the responder.
// slave = responder side, master = GPU and memory side.
interface gpu_mem_responder_if;
    logic         i_command;
    logic         o_busy;
    logic [1:0]   i_commandSize;
    logic         i_write;
    logic [14:0]  i_adr;
    logic [2:0]   i_subadr;
    logic [15:0]  i_writeMask;
    logic [255:0] i_dataOut;
    logic [255:0] o_dataIn;
    logic         o_dataInValid;
    logic [16:0]  o_memAdr;
    logic         o_memWe;
    logic         o_memRe;
    logic [7:0]   o_memBe;
    logic [63:0]  o_memWData;
    logic [63:0]  i_memRData;

    modport slave (
        input  i_command, i_commandSize, i_write, i_adr, i_subadr, i_writeMask,
        input  i_dataOut, i_memRData,
        output o_busy, o_dataIn, o_dataInValid,
        output o_memAdr, o_memWe, o_memRe, o_memBe, o_memWData
    );

    modport master (
        output i_command, i_commandSize, i_write, i_adr, i_subadr, i_writeMask,
        output i_dataOut, i_memRData,
        input  o_busy, o_dataIn, o_dataInValid,
        input  o_memAdr, o_memWe, o_memRe, o_memBe, o_memWData
    );
endinterface

// File: rtl/gpu_mem_beat_sel.sv
// Combinational next-beat picker and mask-to-byte-enable expander; zero latency, no backpressure.
// With GPU_MEM_RESP_BEAT_SKIP_EN, full-block writes priority-encode past beats whose mask nibble is 0.
module gpu_mem_beat_sel
    import gpu_mem_pkg::*;
(
    input  logic [15:0] mask,
    input  cmd_size_e   size,
    input  logic [2:0]  subadr,
    input  logic        write,
    input  logic [1:0]  start,
    output logic [1:0]  beat,
    output logic [7:0]  be,
    output logic        found,
    output logic        last
);

`ifdef GPU_MEM_RESP_BEAT_SKIP_EN
    logic [BEATS_PER_BLOCK-1:0] grp_nz;

    always_comb begin
        grp_nz = '0;
        for (int b = 0; b < BEATS_PER_BLOCK; b++) grp_nz[b] = |mask[4*b +: 4];
    end
`endif

    always_comb begin
        beat  = start;
        found = 1'b1;
        last  = (start == 2'(BEATS_PER_BLOCK - 1));
        if (!is_full_block(size)) begin
            beat = subadr[2:1];
            last = 1'b1;
`ifdef GPU_MEM_RESP_BEAT_SKIP_EN
            found = !write || grp_nz[subadr[2:1]];
`endif
        end
`ifdef GPU_MEM_RESP_BEAT_SKIP_EN
        else if (write) begin
            // Descending scan so the lowest qualifying beat wins.
            found = 1'b0;
            for (int b = BEATS_PER_BLOCK - 1; b >= 0; b--) begin
                if (2'(b) >= start && grp_nz[b]) begin
                    beat  = 2'(b);
                    found = 1'b1;
                end
            end
            last = 1'b1;
            for (int b = 0; b < BEATS_PER_BLOCK; b++) begin
                if (2'(b) > beat && grp_nz[b]) last = 1'b0;
            end
        end
`endif
        be = '0;
        for (int j = 0; j < 8; j++) be[j] = mask[{beat, 2'(j / 2)}];
        if (size == SZ_4B) be = be & (subadr[0] ? 8'hF0 : 8'h0F);
        if (!write) be = '0;
    end

endmodule

// File: rtl/gpu_mem_responder.sv
// GPU block responder: splits 4/8/32-byte commands into 64-bit memory beats; first beat one cycle after accept.
// o_busy blocks new commands; feature macro GPU_MEM_RESP_BEAT_SKIP_EN drops all-zero-mask write beats.
module gpu_mem_responder
    import gpu_mem_pkg::*;
(
    input  logic               clk,
    input  logic               i_nrst,
    gpu_mem_responder_if.slave gpu
);

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         wr_q, wr_d;
    cmd_size_e    size_q, size_d;
    logic [14:0]  adr_q, adr_d;
    logic [2:0]   sub_q, sub_d;
    logic [15:0]  mask_q, mask_d;
    logic [255:0] wdat_q, wdat_d;
    logic [1:0]   beat_q, beat_d;
    logic         last_q, last_d;
    logic [1:0]   drain_q, drain_d;
    logic         mem_we_q, mem_we_d;
    logic         mem_re_q, mem_re_d;
    logic [7:0]   mem_be_q, mem_be_d;
    logic [16:0]  mem_adr_q, mem_adr_d;
    logic [63:0]  mem_wdat_q, mem_wdat_d;
    logic         cap_vld_q, cap_vld_d;
    logic [1:0]   cap_beat_q, cap_beat_d;
    logic [255:0] rdat_q, rdat_d;
    logic         rdat_vld_q, rdat_vld_d;

    logic         accept, issue;
    logic         sel_wr;
    cmd_size_e    sel_size;
    logic [14:0]  sel_adr;
    logic [2:0]   sel_sub;
    logic [15:0]  sel_mask;
    logic [255:0] sel_wdat;
    logic [1:0]   sel_start;
    logic [1:0]   nb_beat;
    logic [7:0]   nb_be;
    logic         nb_found, nb_last;

    // The first beat is chosen from the live request so it can issue right after acceptance.
    assign accept    = gpu.i_command && !busy_q;
    assign sel_wr    = accept ? gpu.i_write : wr_q;
    assign sel_size  = accept ? cmd_size_e'(gpu.i_commandSize) : size_q;
    assign sel_adr   = accept ? gpu.i_adr : adr_q;
    assign sel_sub   = accept ? gpu.i_subadr : sub_q;
    assign sel_mask  = accept ? gpu.i_writeMask : mask_q;
    assign sel_wdat  = accept ? gpu.i_dataOut : wdat_q;
    assign sel_start = accept ? 2'd0 : beat_q + 2'd1;

    gpu_mem_beat_sel u_beat_sel (
        .mask   (sel_mask),
        .size   (sel_size),
        .subadr (sel_sub),
        .write  (sel_wr),
        .start  (sel_start),
        .beat   (nb_beat),
        .be     (nb_be),
        .found  (nb_found),
        .last   (nb_last)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        wr_d       = wr_q;
        size_d     = size_q;
        adr_d      = adr_q;
        sub_d      = sub_q;
        mask_d     = mask_q;
        wdat_d     = wdat_q;
        beat_d     = beat_q;
        last_d     = last_q;
        drain_d    = drain_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_be_d   = '0;
        mem_adr_d  = mem_adr_q;
        mem_wdat_d = mem_wdat_q;
        cap_vld_d  = mem_re_q;
        cap_beat_d = beat_q;
        rdat_d     = rdat_q;
        rdat_vld_d = 1'b0;
        issue      = 1'b0;

        if (cap_vld_q) rdat_d[{cap_beat_q, 6'd0} +: 64] = gpu.i_memRData;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d = gpu.i_write ? WRITE : READ;
                    busy_d  = 1'b1;
                    wr_d    = gpu.i_write;
                    size_d  = sel_size;
                    adr_d   = gpu.i_adr;
                    sub_d   = gpu.i_subadr;
                    mask_d  = gpu.i_writeMask;
                    wdat_d  = gpu.i_dataOut;
                    issue   = 1'b1;
                    if (!gpu.i_write) rdat_d = '0;
                end
            end
            WRITE: begin
                if (last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            READ: begin
                if (!last_q) begin
                    issue = 1'b1;
                end else if (drain_q != 2'd0) begin
                    drain_d = drain_q - 2'd1;
                end else begin
                    state_d    = RESP;
                    busy_d     = 1'b0;
                    rdat_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            beat_d    = nb_beat;
            last_d    = nb_last || !nb_found;
            drain_d   = 2'(READ_LATENCY);
            mem_adr_d = {sel_adr, nb_beat};
            mem_we_d  = sel_wr && nb_found;
            mem_re_d  = !sel_wr;
            mem_be_d  = nb_found ? nb_be : 8'h00;
            if (sel_wr && nb_found) mem_wdat_d = sel_wdat[{nb_beat, 6'd0} +: 64];
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= SZ_8B;
            adr_q      <= '0;
            sub_q      <= '0;
            mask_q     <= '0;
            wdat_q     <= '0;
            beat_q     <= '0;
            last_q     <= 1'b0;
            drain_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_adr_q  <= '0;
            mem_wdat_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_beat_q <= '0;
            rdat_q     <= '0;
            rdat_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            adr_q      <= adr_d;
            sub_q      <= sub_d;
            mask_q     <= mask_d;
            wdat_q     <= wdat_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            drain_q    <= drain_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            mem_be_q   <= mem_be_d;
            mem_adr_q  <= mem_adr_d;
            mem_wdat_q <= mem_wdat_d;
            cap_vld_q  <= cap_vld_d;
            cap_beat_q <= cap_beat_d;
            rdat_q     <= rdat_d;
            rdat_vld_q <= rdat_vld_d;
        end
    end

    assign gpu.o_busy        = busy_q;
    assign gpu.o_dataIn      = rdat_q;
    assign gpu.o_dataInValid = rdat_vld_q;
    assign gpu.o_memAdr      = mem_adr_q;
    assign gpu.o_memWe       = mem_we_q;
    assign gpu.o_memRe       = mem_re_q;
    assign gpu.o_memBe       = mem_be_q;
    assign gpu.o_memWData    = mem_wdat_q;

endmodule

// File: doc/gpu_mem_responder.md
GPU_MEM_RESPONDER -- requirements
Module: gpu_mem_responder

Interface
REQ-001 SHALL have one clock, clk (input, 1): all logic rising-edge.
REQ-002 SHALL have reset i_nrst (input, 1): asynchronous, active-low.
REQ-003 SHALL have i_command (input, 1): request strobe from the GPU.
REQ-004 SHALL have o_busy (output, 1): when high, i_command is ignored.
REQ-005 SHALL have i_commandSize (input, 2): 0=8B, 1=32B, 2=4B, 3=treated as 32B.
REQ-006 SHALL have i_write (input, 1): 1 for write, 0 for read.
REQ-007 SHALL have i_adr (input, 15): index of a 32-byte block.
REQ-008 SHALL have i_subadr (input, 3): 4-byte unit within the block.
REQ-009 SHALL have i_writeMask (input, 16): bit i enables block bytes 2i and 2i+1.
REQ-010 SHALL have i_dataOut (input, 256): write data, block byte k at bits [8k+7:8k].
REQ-011 SHALL have o_dataIn (output, 256) and o_dataInValid (output, 1): read return.
REQ-012 SHALL have backing port o_memAdr (output, 17), equal to {block, beat}.
REQ-013 SHALL have o_memWe (output, 1), o_memRe (output, 1), o_memBe (output, 8) and o_memWData (output, 64).
REQ-014 SHALL have i_memRData (input, 64): valid exactly one cycle after o_memRe.

Function
REQ-015 SHALL accept a command in cycle T0 when i_command=1 and o_busy=0, registering all request inputs; o_busy SHALL be 1 from T1.
REQ-016 SHALL sequence with FSM states IDLE, WRITE, READ, RESP.
REQ-017 SHALL use 64-bit beat b (0..3) for block bytes 8b..8b+7, with o_memBe[j] = mask bit (4b + j/2).
REQ-018 SHALL execute a 32B write in WRITE as beats 0..3 at T1..T4, then IDLE with o_busy=0 at T5.
REQ-019 SHALL execute an 8B write as the single beat i_subadr[2:1] at T1, with o_busy=0 at T2.
REQ-020 SHALL execute a 4B write the same way, additionally restricting o_memBe to half i_subadr[0] (bits 3:0 or 7:4).
REQ-021 SHALL execute a 32B read in READ with o_memRe on beats 0..3 at T1..T4, capturing beats at T2..T5; RESP SHALL pulse o_dataInValid=1 for one cycle at T6, with o_busy=0 in that same cycle.
REQ-022 SHALL execute an 8B or 4B read as the single beat i_subadr[2:1] at T1, with o_dataInValid at T3 and that beat in lanes [64b+63:64b]; the other lanes SHALL be 0.
REQ-023 SHALL hold o_dataIn until the next read's capture, and SHALL clear unfetched lanes at acceptance.
REQ-024 SHALL allow a new command to be accepted in the cycle o_busy returns to 0, including the RESP cycle.
REQ-025 SHALL never assert o_memWe and o_memRe in the same cycle.
REQ-026 SHALL drive o_memWe, o_memRe and o_memBe to 0 outside active beats.

Reset
REQ-027 SHALL, on i_nrst low at any time, immediately force IDLE, o_busy=0, o_dataInValid=0, o_memWe=0, o_memRe=0, o_memBe=0, o_memAdr=0, o_memWData=0 and o_dataIn=0.
REQ-028 SHALL abort any in-flight operation on reset with no deferred o_dataInValid pulse.

Configuration
REQ-029 SHALL provide macro GPU_MEM_RESP_BEAT_SKIP_EN: when defined, write beats whose 4 mask bits are all 0 SHALL be skipped with zero cycle cost, the next beat coming from a priority encoder.
REQ-030 SHALL, for an all-zero-mask write with the macro defined, spend one WRITE cycle with no o_memWe and drop o_busy at T2.
REQ-031 SHALL, without the macro, issue every write beat per REQ-018..020, with o_memWe=1 even when o_memBe=0.

Structure
REQ-032 SHALL place size encodings, BEATS_PER_BLOCK=4, read latency 1 and the FSM state enum in shared package gpu_mem_pkg.
REQ-033 SHALL implement mask-to-byte-enable expansion and next-beat selection in sub-module gpu_mem_beat_sel.

Verification
REQ-034 SHALL cover: 32B write, adr=0x0123, mask=0xFFFF -> o_memAdr 0x048C..0x048F at T1..T4, o_memBe=0xFF each beat, o_busy low at T5.
REQ-035 SHALL cover: 8B read, adr=0x7FFF, subadr=6, memory returning 0xDEADBEEF_CAFEF00D -> o_memAdr=0x1FFFF, o_dataInValid at T3, o_dataIn[255:192]=that value, rest 0.
REQ-036 SHALL cover: 4B write, subadr=5, mask=0xFFFF -> single beat 2, o_memBe=0xF0.
REQ-037 SHALL cover: 32B write, mask=0x0F00 -> with macro only beat 2 written and o_busy low at T2; without macro 4 beats, o_memBe=00,00,FF,00.
REQ-038 SHALL cover: reset asserted at T3 of a 32B read -> all outputs 0 immediately, no o_dataInValid afterward.
REQ-039 SHALL cover: back-to-back reads, second command held high through the first -> second accepted in the first's RESP cycle, with no idle gap.
